// File: rtl/mod_exp_ctrl_pkg.sv
// Shared project package for the modular-exponentiation controller.
// Holds the FSM state encoding, the default exponent width and the
// datapath widths used by the controller and its multiplier bus.
package mod_exp_ctrl_pkg;

    localparam int EXP_W_DEFAULT = 32;
    localparam int DATA_W        = 32;
    localparam int LEN_W         = 8;
    localparam int BITS_W        = 6;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_LOAD,
        ST_SQR_ISSUE,
        ST_SQR_WAIT,
        ST_MUL_ISSUE,
        ST_MUL_WAIT,
        ST_CONV_ISSUE,
        ST_CONV_WAIT,
        ST_DONE
    } state_t;

    // Requests asking for more bits than the exponent register holds are
    // treated as a full-width exponent.
    function automatic logic [BITS_W-1:0] clamp_bits(input logic [BITS_W-1:0] bits,
                                                     input logic [BITS_W-1:0] max_bits);
        return (bits > max_bits) ? max_bits : bits;
    endfunction

endpackage

// File: rtl/mod_exp_ctrl_if.sv
// Montgomery multiplier request/response bus.
// master: the exponentiation controller (drives mm_start and operands,
//         receives mm_end / mm_out).
// slave : the shared Montgomery multiplier.
//   mm_start   one-cycle operation request
//   mm_len     operand length, passed through unchanged
//   mm_num_1   first operand
//   mm_num_2   second operand
//   mm_modulus modulus N
//   mm_end     one-cycle completion strobe
//   mm_out     product a*b*R^-1 mod N, valid with mm_end
interface mod_exp_ctrl_if import mod_exp_ctrl_pkg::*; ();

    logic              mm_start;
    logic [LEN_W-1:0]  mm_len;
    logic [DATA_W-1:0] mm_num_1;
    logic [DATA_W-1:0] mm_num_2;
    logic [DATA_W-1:0] mm_modulus;
    logic              mm_end;
    logic [DATA_W-1:0] mm_out;

    modport master (
        output mm_start, mm_len, mm_num_1, mm_num_2, mm_modulus,
        input  mm_end, mm_out
    );

    modport slave (
        input  mm_start, mm_len, mm_num_1, mm_num_2, mm_modulus,
        output mm_end, mm_out
    );

endinterface

// File: rtl/mod_exp_ctrl.sv
// Left-to-right square-and-multiply controller for Montgomery modular
// exponentiation. The multiplier itself lives outside this block and is
// reached through the mm bus so a top level can share it.
// Ports:
//   clk, rstn       clock, synchronous active-low reset
//   start           request, accepted only when idle
//   len             operand length forwarded to the multiplier
//   base_m, one_m   base and R mod N, both in Montgomery form
//   exponent        exponent value
//   exp_bits        number of exponent bits to process (clamped to EXP_W)
//   modulus         modulus N
//   busy            operation in progress
//   done            one-cycle pulse, result valid in the same cycle
//   result          base^exponent mod N in normal form
//   mm              master side of the multiplier bus
module mod_exp_ctrl import mod_exp_ctrl_pkg::*; #(
    parameter int EXP_W = EXP_W_DEFAULT
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              start,
    input  logic [LEN_W-1:0]  len,
    input  logic [DATA_W-1:0] base_m,
    input  logic [DATA_W-1:0] one_m,
    input  logic [EXP_W-1:0]  exponent,
    input  logic [BITS_W-1:0] exp_bits,
    input  logic [DATA_W-1:0] modulus,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] result,
    mod_exp_ctrl_if.master    mm
);

    localparam int                IDX_W     = (EXP_W > 1) ? $clog2(EXP_W) : 1;
    localparam logic [BITS_W-1:0] EXP_W_MAX = BITS_W'(EXP_W);

    state_t            state_q, state_d;
    logic [LEN_W-1:0]  len_q, len_d;
    logic [DATA_W-1:0] base_m_q, base_m_d;
    logic [DATA_W-1:0] one_m_q, one_m_d;
    logic [EXP_W-1:0]  exponent_q, exponent_d;
    logic [BITS_W-1:0] exp_bits_q, exp_bits_d;
    logic [DATA_W-1:0] modulus_q, modulus_d;
    logic [DATA_W-1:0] acc_q, acc_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [DATA_W-1:0] result_q, result_d;
    logic [DATA_W-1:0] num_1_q, num_1_d;
    logic [DATA_W-1:0] num_2_q, num_2_d;

    // State and datapath registers; reset aborts any operation in flight.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q    <= ST_IDLE;
            len_q      <= '0;
            base_m_q   <= '0;
            one_m_q    <= '0;
            exponent_q <= '0;
            exp_bits_q <= '0;
            modulus_q  <= '0;
            acc_q      <= '0;
            idx_q      <= '0;
            result_q   <= '0;
            num_1_q    <= '0;
            num_2_q    <= '0;
        end else begin
            state_q    <= state_d;
            len_q      <= len_d;
            base_m_q   <= base_m_d;
            one_m_q    <= one_m_d;
            exponent_q <= exponent_d;
            exp_bits_q <= exp_bits_d;
            modulus_q  <= modulus_d;
            acc_q      <= acc_d;
            idx_q      <= idx_d;
            result_q   <= result_d;
            num_1_q    <= num_1_d;
            num_2_q    <= num_2_d;
        end
    end

    // Next-state logic. After each bit (squaring, plus the optional
    // multiply) the index either steps down or the accumulator is
    // converted out of Montgomery form by multiplying with plain 1.
    always_comb begin
        state_d    = state_q;
        len_d      = len_q;
        base_m_d   = base_m_q;
        one_m_d    = one_m_q;
        exponent_d = exponent_q;
        exp_bits_d = exp_bits_q;
        modulus_d  = modulus_q;
        acc_d      = acc_q;
        idx_d      = idx_q;
        result_d   = result_q;
        num_1_d    = num_1_q;
        num_2_d    = num_2_q;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    len_d      = len;
                    base_m_d   = base_m;
                    one_m_d    = one_m;
                    exponent_d = exponent;
                    exp_bits_d = clamp_bits(exp_bits, EXP_W_MAX);
                    modulus_d  = modulus;
                    state_d    = ST_LOAD;
                end
            end
            ST_LOAD: begin
                acc_d   = one_m_q;
                idx_d   = IDX_W'(exp_bits_q - 1'b1);
                state_d = (exp_bits_q != '0) ? ST_SQR_ISSUE : ST_CONV_ISSUE;
            end
            ST_SQR_ISSUE:  state_d = ST_SQR_WAIT;
            ST_SQR_WAIT: begin
                if (mm.mm_end) begin
                    acc_d = mm.mm_out;
                    if (exponent_q[idx_q]) begin
                        state_d = ST_MUL_ISSUE;
                    end else if (idx_q == '0) begin
                        state_d = ST_CONV_ISSUE;
                    end else begin
                        idx_d   = idx_q - 1'b1;
                        state_d = ST_SQR_ISSUE;
                    end
                end
            end
            ST_MUL_ISSUE:  state_d = ST_MUL_WAIT;
            ST_MUL_WAIT: begin
                if (mm.mm_end) begin
                    acc_d = mm.mm_out;
                    if (idx_q == '0) begin
                        state_d = ST_CONV_ISSUE;
                    end else begin
                        idx_d   = idx_q - 1'b1;
                        state_d = ST_SQR_ISSUE;
                    end
                end
            end
            ST_CONV_ISSUE: state_d = ST_CONV_WAIT;
            ST_CONV_WAIT: begin
                if (mm.mm_end) begin
                    result_d = mm.mm_out;
                    state_d  = ST_DONE;
                end
            end
            ST_DONE:       state_d = ST_IDLE;
            default:       state_d = ST_IDLE;
        endcase

        // Operands are registered on entry to an issue state so they are
        // already valid with mm_start and stay put through the wait.
        if (state_d != state_q) begin
            case (state_d)
                ST_SQR_ISSUE: begin
                    num_1_d = acc_d;
                    num_2_d = acc_d;
                end
                ST_MUL_ISSUE: begin
                    num_1_d = acc_d;
                    num_2_d = base_m_q;
                end
                ST_CONV_ISSUE: begin
                    num_1_d = acc_d;
                    num_2_d = DATA_W'(1);
                end
                default: begin
                    num_1_d = num_1_q;
                    num_2_d = num_2_q;
                end
            endcase
        end
    end

    assign busy          = (state_q != ST_IDLE) && (state_q != ST_DONE);
    assign done          = (state_q == ST_DONE);
    assign result        = result_q;
    assign mm.mm_start   = (state_q == ST_SQR_ISSUE) || (state_q == ST_MUL_ISSUE) ||
                           (state_q == ST_CONV_ISSUE);
    assign mm.mm_len     = len_q;
    assign mm.mm_num_1   = num_1_q;
    assign mm.mm_num_2   = num_2_q;
    assign mm.mm_modulus = modulus_q;

endmodule
